// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave
// Description : SPI slave register bank. Oversamples already-synchronized SPI
//               pins on the system clock, supports CPOL/CPHA modes 0-3, and
//               runs an 8-bit command + REG_WIDTH-bit data frame. Config
//               registers are SPI-writable; status registers are read-only
//               snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_slave #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             cfg_wr_pulse,
    output logic [2:0]                       cfg_wr_addr
);

    localparam int CMD_BITS = 8;
    localparam int CNT_MAX  = (REG_WIDTH > CMD_BITS) ? REG_WIDTH : CMD_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(REG_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                         state_q,   state_d;
    logic                           cs_n_q,    cs_n_d;
    logic                           spi_clk_q, spi_clk_d;
    logic [1:0]                     mode_q,    mode_d;
    logic [CNT_W-1:0]               cnt_q,     cnt_d;
    logic [CMD_BITS-2:0]            cmd_q,     cmd_d;
    logic [REG_WIDTH-2:0]           rx_q,      rx_d;
    logic [REG_WIDTH-1:0]           tx_q,      tx_d;
    logic [2:0]                     addr_q,    addr_d;
    logic                           wr_ok_q,   wr_ok_d;
    logic                           miso_q,    miso_d;
    logic [NUM_CFG*REG_WIDTH-1:0]   cfg_q,     cfg_d;
    logic                           pulse_q,   pulse_d;
    logic [2:0]                     wr_addr_q, wr_addr_d;

    logic                 w_edge;
    logic                 w_lead;
    logic                 w_trail;
    logic                 w_sample;
    logic                 w_shift;
    logic                 w_rw;
    logic                 w_bank;
    logic [2:0]           w_addr;
    logic [REG_WIDTH-1:0] w_data;
    logic                 w_cfg_hit;
    logic [REG_WIDTH-1:0] w_cfg_val;
    logic [REG_WIDTH-1:0] w_st_val;
    logic [REG_WIDTH-1:0] w_snap;

    // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
    assign w_edge   = (spi_clk != spi_clk_q);
    assign w_lead   = w_edge && (spi_clk_q == mode_q[1]);
    assign w_trail  = w_edge && (spi_clk_q != mode_q[1]);
    assign w_sample = mode_q[0] ? w_trail : w_lead;
    assign w_shift  = mode_q[0] ? w_lead  : w_trail;

    // Command fields as seen on the clk that takes the 8th command bit.
    assign w_rw   = cmd_q[6];
    assign w_bank = cmd_q[2];
    assign w_addr = {cmd_q[1:0], spi_mosi};
    assign w_data = {rx_q, spi_mosi};

    // Decode the addressed register; unmapped addresses read as zero.
    always_comb begin
        w_cfg_hit = 1'b0;
        w_cfg_val = '0;
        w_st_val  = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (w_addr == 3'(k)) begin
                w_cfg_hit = 1'b1;
                w_cfg_val = cfg_q[k*REG_WIDTH +: REG_WIDTH];
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (w_addr == 3'(k)) begin
                w_st_val = status_regs[k*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign w_snap = w_bank ? w_st_val : w_cfg_val;

    // Frame FSM, shift registers and commit logic; CS high always wins.
    always_comb begin
        state_d   = state_q;
        cs_n_d    = spi_cs_n;
        spi_clk_d = spi_clk;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_ok_d   = wr_ok_q;
        miso_d    = miso_q;
        cfg_d     = cfg_q;
        pulse_d   = 1'b0;
        wr_addr_d = wr_addr_q;

        if (spi_cs_n) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_n_q) begin
                        state_d = ST_CMD;
                        mode_d  = mode;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (w_sample) begin
                        cmd_d = {cmd_q[CMD_BITS-3:0], spi_mosi};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_CMD_LAST) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                            addr_d  = w_addr;
                            wr_ok_d = w_rw && !w_bank && w_cfg_hit;
                            tx_d    = w_rw ? '0 : w_snap;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_shift) begin
                        miso_d = tx_q[REG_WIDTH-1];
                        tx_d   = tx_q << 1;
                    end
                    if (w_sample) begin
                        rx_d  = w_data[REG_WIDTH-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_DATA_LAST) begin
                            state_d = ST_DONE;
                            miso_d  = 1'b0;
                            if (wr_ok_q) begin
                                for (int k = 0; k < NUM_CFG; k++) begin
                                    if (addr_q == 3'(k)) begin
                                        cfg_d[k*REG_WIDTH +: REG_WIDTH] = w_data;
                                    end
                                end
                                pulse_d   = 1'b1;
                                wr_addr_d = addr_q;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // State register; ena low freezes everything including edge history.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= ST_IDLE;
            cs_n_q    <= 1'b1;
            spi_clk_q <= 1'b0;
            mode_q    <= 2'b00;
            cnt_q     <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= 3'd0;
            wr_ok_q   <= 1'b0;
            miso_q    <= 1'b0;
            cfg_q     <= '0;
            pulse_q   <= 1'b0;
            wr_addr_q <= 3'd0;
        end else if (ena) begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            spi_clk_q <= spi_clk_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_ok_q   <= wr_ok_d;
            miso_q    <= miso_d;
            cfg_q     <= cfg_d;
            pulse_q   <= pulse_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign spi_miso     = miso_q;
    assign config_regs  = cfg_q;
    assign cfg_wr_pulse = pulse_q;
    assign cfg_wr_addr  = wr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_slave
// Description : Randomized SPI master driving spi_reg_slave, with a register
//               model producing expected writes and read-back bytes into
//               queues that a separate monitor compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

    localparam int NCFG = 4;
    localparam int NST  = 6;
    localparam int W    = 8;

    logic              clk  = 1'b0;
    logic              rstb = 1'b0;
    logic              ena  = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              cs_n = 1'b1;
    logic              sck  = 1'b0;
    logic              mosi = 1'b0;
    logic              miso;
    logic [NCFG*W-1:0] cfg_regs;
    logic [NST*W-1:0]  st_regs;
    logic              pulse;
    logic [2:0]        waddr;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] got_rd_q[$];

    logic [7:0] m_cfg [NCFG];
    logic [7:0] m_st  [NST];

    int n_checks = 0;
    int n_pass   = 0;

    spi_reg_slave #(
        .NUM_CFG    (NCFG),
        .NUM_STATUS (NST),
        .REG_WIDTH  (W)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .mode         (mode),
        .spi_cs_n     (cs_n),
        .spi_clk      (sck),
        .spi_mosi     (mosi),
        .spi_miso     (miso),
        .config_regs  (cfg_regs),
        .status_regs  (st_regs),
        .cfg_wr_pulse (pulse),
        .cfg_wr_addr  (waddr)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NST; k++) st_regs[k*W +: W] = m_st[k];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        f = '0;
        for (int k = 0; k < NCFG; k++) f[k*W +: W] = m_cfg[k];
        return f;
    endfunction

    function automatic logic [7:0] ref_read(input logic [7:0] c);
        int a;
        a = int'(c[2:0]);
        if (c[3]) return (a < NST) ? m_st[a] : 8'h00;
        return (a < NCFG) ? m_cfg[a] : 8'h00;
    endfunction

    // One SPI frame: command, nd data bits, optional extra SCK pulses.
    task automatic frame(input logic [1:0] m, input logic [7:0] c, input logic [7:0] d,
                         input int nd, input int extra, input int hp, input bit live);
        logic [15:0] bits;
        logic [7:0]  got;
        wr_t         e;
        bit          cpol, cpha;
        bits = {c, d};
        cpol = m[1];
        cpha = m[0];
        got  = '0;
        if (live && nd == 8) begin
            exp_rd_q.push_back(c[7] ? 8'h00 : ref_read(c));
            if (c[7] && !c[3] && int'(c[2:0]) < NCFG) begin
                e.a = c[2:0];
                e.d = d;
                exp_wr_q.push_back(e);
                m_cfg[c[2:0]] = d;
            end
        end
        mode = m;
        sck  = cpol;
        mosi = bits[15];
        wclk(hp);
        cs_n = 1'b0;
        wclk(2);
        mode = 2'($urandom);
        wclk(hp);
        for (int i = 0; i < 8 + nd; i++) begin
            if (!cpha) begin
                mosi = bits[15-i];
                if (i >= 8) got[15-i] = miso;
                sck = ~cpol;
                wclk(hp);
                sck = cpol;
                wclk(hp);
            end else begin
                sck  = ~cpol;
                mosi = bits[15-i];
                wclk(hp);
                if (i >= 8) got[15-i] = miso;
                sck = cpol;
                wclk(hp);
            end
        end
        for (int x = 0; x < extra; x++) begin
            sck  = ~cpol;
            mosi = 1'($urandom);
            wclk(hp);
            sck = cpol;
            wclk(hp);
        end
        cs_n = 1'b1;
        wclk(hp);
        if (live && nd == 8) got_rd_q.push_back(got);
    endtask

    // Monitor: pops expectations whenever the DUT commits or a read completes.
    initial begin
        wr_t        e;
        logic [7:0] g, x;
        forever begin
            @(negedge clk);
            if (pulse) begin
                if (exp_wr_q.size() == 0) begin
                    check("spurious_pulse", {31'd0, pulse}, 32'd0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", {29'd0, waddr}, {29'd0, e.a});
                    check("wr_data", {24'd0, cfg_regs[int'(e.a)*W +: W]}, {24'd0, e.d});
                end
            end
            if (got_rd_q.size() > 0) begin
                g = got_rd_q.pop_front();
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(got_rd_q.size() + 1), 32'd0);
                end else begin
                    x = exp_rd_q.pop_front();
                    check("miso_byte", {24'd0, g}, {24'd0, x});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, d;
        int         nd;
        for (int k = 0; k < NCFG; k++) m_cfg[k] = 8'h00;
        for (int k = 0; k < NST; k++) m_st[k] = 8'($urandom);
        m_st[0] = 8'h3C;

        wclk(3);
        check("rst_cfg",   cfg_regs, 32'd0);
        check("rst_miso",  {31'd0, miso},  32'd0);
        check("rst_pulse", {31'd0, pulse}, 32'd0);
        check("rst_waddr", {29'd0, waddr}, 32'd0);
        rstb = 1'b1;
        wclk(5);

        frame(2'd0, 8'h81, 8'hA5, 8, 0, 5, 1);
        check("cfg_after_a5", cfg_regs, model_flat());
        check("waddr_after_a5", {29'd0, waddr}, 32'd1);

        for (int m = 0; m < 4; m++) frame(2'(m), 8'h08, 8'h00, 8, 1, 4 + m, 1);

        frame(2'd1, 8'h82, 8'h5A, 8, 0, 4, 1);
        frame(2'd2, 8'h02, 8'h00, 8, 0, 6, 1);

        frame(2'd0, 8'h83, 8'h77, 4, 0, 5, 1);
        check("cfg_after_abort", cfg_regs, model_flat());

        frame(2'd3, 8'h88, 8'hFF, 8, 0, 4, 1);
        frame(2'd0, 8'h85, 8'hFF, 8, 0, 5, 1);
        check("cfg_after_illegal", cfg_regs, model_flat());
        frame(2'd1, 8'h05, 8'h00, 8, 0, 5, 1);

        ena = 1'b0;
        frame(2'd0, 8'h80, 8'hC3, 8, 0, 5, 0);
        ena = 1'b1;
        wclk(5);
        check("cfg_after_frozen", cfg_regs, model_flat());

        for (int i = 0; i < 45; i++) begin
            c  = 8'($urandom);
            d  = 8'($urandom);
            nd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
            frame(2'($urandom), c, d, nd, int'($urandom_range(0, 2)), int'($urandom_range(4, 7)), 1);
            check("cfg_rand", cfg_regs, model_flat());
        end

        // Reset asserted in the middle of a write frame.
        frame(2'd0, 8'h80, 8'h3E, 8, 0, 4, 1);
        mode = 2'd0;
        sck  = 1'b0;
        mosi = 1'b1;
        wclk(4);
        cs_n = 1'b0;
        wclk(5);
        for (int i = 0; i < 5; i++) begin
            sck = 1'b1;
            wclk(4);
            sck = 1'b0;
            wclk(4);
        end
        rstb = 1'b0;
        #1;
        check("midrst_cfg",   cfg_regs, 32'd0);
        check("midrst_miso",  {31'd0, miso},  32'd0);
        check("midrst_pulse", {31'd0, pulse}, 32'd0);
        for (int k = 0; k < NCFG; k++) m_cfg[k] = 8'h00;
        wclk(3);
        rstb = 1'b1;
        cs_n = 1'b1;
        wclk(5);
        frame(2'd3, 8'h83, 8'h96, 8, 0, 5, 1);
        frame(2'd0, 8'h03, 8'h00, 8, 0, 5, 1);
        check("cfg_after_midrst", cfg_regs, model_flat());

        wclk(20);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
